lsc_i2cm_arb: RTL and testbench

//  Two-port arbiter/scheduler for the shared 16-bit-offset I2C master engine (lsc_i2cm_16).

---
 rtl/lsc_i2cm_arb_if.sv | 37 +++
 rtl/lsc_i2cm_arb.sv | 121 ++++++++++++
 tb/tb_lsc_i2cm_arb.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsc_i2cm_arb_if.sv
// Bundle between the two requesting ports, the arbiter and the shared I2C master engine.
// Requests are level valids: reqN rises with rwN/ofsN/wdatN stable and stays up until the
// cycle after ackN; ackN is a one-cycle response, and m_run/m_done form a pulse pair with
// the engine, which reports occupancy on m_running.
interface lsc_i2cm_arb_if;
  logic        req0, req1;
  logic        rw0, rw1;
  logic [15:0] ofs0, ofs1;
  logic [7:0]  wdat0, wdat1;
  logic        ack0, ack1;
  logic        err0, err1;
  logic [7:0]  rdat;
  logic        busy;
  logic        m_run;
  logic        m_rw;
  logic [15:0] m_ofs;
  logic [7:0]  m_wdat;
  logic [6:0]  m_dev;
  logic [5:0]  m_intv;
  logic        m_running;
  logic        m_done;
  logic [7:0]  m_rdat;

  modport slave (
    input  req0, req1, rw0, rw1, ofs0, ofs1, wdat0, wdat1,
    output ack0, ack1, err0, err1, rdat, busy,
    output m_run, m_rw, m_ofs, m_wdat, m_dev, m_intv,
    input  m_running, m_done, m_rdat
  );

  modport master (
    output req0, req1, rw0, rw1, ofs0, ofs1, wdat0, wdat1,
    input  ack0, ack1, err0, err1, rdat, busy,
    input  m_run, m_rw, m_ofs, m_wdat, m_dev, m_intv,
    output m_running, m_done, m_rdat
  );
endinterface

// File: rtl/lsc_i2cm_arb.sv
// Two-port scheduler in front of lsc_i2cm_16: grants one port, issues a single run pulse,
// waits for m_done (or the watchdog) and returns ack/err/rdat to the granted port.
module lsc_i2cm_arb #(
  parameter logic [6:0] DEV_ADDR = 7'h24,
  parameter logic [5:0] INTERVAL = 6'd30,
  parameter bit         PRIO0    = 1'b1,
  parameter int         TMO_W    = 20
) (
  input  logic               clk,
  input  logic               resetn,
  lsc_i2cm_arb_if.slave      bus,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK} state_t;

  // Abort on the S_WAIT cycle where wdog is about to reach all-ones,
  // so S_WAIT lasts at most 2**TMO_W-1 cycles.
  localparam logic [TMO_W-1:0] WDOG_LAST = {{(TMO_W-1){1'b1}}, 1'b0};
  localparam logic [TMO_W-1:0] WDOG_ONE  = {{(TMO_W-1){1'b0}}, 1'b1};

  state_t            state, state_nxt;
  logic              gnt, gnt_nxt;
  logic              last_gnt, last_gnt_nxt;
  logic              err, err_nxt;
  logic [TMO_W-1:0]  wdog, wdog_nxt;
  logic [7:0]        rdat_q, rdat_nxt;
  logic              m_rw_q, m_rw_nxt;
  logic [15:0]       m_ofs_q, m_ofs_nxt;
  logic [7:0]        m_wdat_q, m_wdat_nxt;
  logic              win;

  always_comb begin
    if (PRIO0)                        win = bus.req0 ? 1'b0 : 1'b1;
    else if (bus.req0 && bus.req1)    win = ~last_gnt;
    else                              win = bus.req1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= S_IDLE;
      gnt      <= 1'b0;
      last_gnt <= 1'b1;
      err      <= 1'b0;
      wdog     <= '0;
      rdat_q   <= '0;
      m_rw_q   <= 1'b0;
      m_ofs_q  <= '0;
      m_wdat_q <= '0;
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      last_gnt <= last_gnt_nxt;
      err      <= err_nxt;
      wdog     <= wdog_nxt;
      rdat_q   <= rdat_nxt;
      m_rw_q   <= m_rw_nxt;
      m_ofs_q  <= m_ofs_nxt;
      m_wdat_q <= m_wdat_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    gnt_nxt      = gnt;
    last_gnt_nxt = last_gnt;
    err_nxt      = err;
    wdog_nxt     = wdog;
    rdat_nxt     = rdat_q;
    m_rw_nxt     = m_rw_q;
    m_ofs_nxt    = m_ofs_q;
    m_wdat_nxt   = m_wdat_q;
    case (state)
      S_IDLE: begin
        // An engine still finishing an aborted transfer blocks new grants.
        if ((bus.req0 || bus.req1) && !bus.m_running) begin
          gnt_nxt      = win;
          last_gnt_nxt = win;
          m_rw_nxt     = win ? bus.rw1   : bus.rw0;
          m_ofs_nxt    = win ? bus.ofs1  : bus.ofs0;
          m_wdat_nxt   = win ? bus.wdat1 : bus.wdat0;
          state_nxt    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wdog_nxt  = '0;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        wdog_nxt = wdog + WDOG_ONE;
        if (bus.m_done) begin
          if (m_rw_q) rdat_nxt = bus.m_rdat;
          err_nxt   = 1'b0;
          state_nxt = S_ACK;
        end else if (wdog == WDOG_LAST) begin
          err_nxt   = 1'b1;
          state_nxt = S_ACK;
        end
      end
      S_ACK: begin
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign bus.ack0   = (state == S_ACK) && !gnt;
  assign bus.ack1   = (state == S_ACK) &&  gnt;
  assign bus.err0   = (state == S_ACK) && !gnt && err;
  assign bus.err1   = (state == S_ACK) &&  gnt && err;
  assign bus.rdat   = rdat_q;
  assign bus.busy   = (state != S_IDLE);
  assign bus.m_run  = (state == S_ISSUE);
  assign bus.m_rw   = m_rw_q;
  assign bus.m_ofs  = m_ofs_q;
  assign bus.m_wdat = m_wdat_q;
  assign bus.m_dev  = DEV_ADDR;
  assign bus.m_intv = INTERVAL;
  assign dbg_state  = state;

endmodule

// File: tb/tb_lsc_i2cm_arb.sv
// Bench for lsc_i2cm_arb: strict-priority instance with an engine model and scoreboard,
// plus a round-robin instance for the alternating-grant case.
module tb_lsc_i2cm_arb;
  localparam int TMO_W   = 4;
  localparam int TMO_LAT = 16;  // m_run cycle to ack cycle on a watchdog abort

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  lsc_i2cm_arb_if a_if();
  lsc_i2cm_arb_if b_if();
  logic [1:0] a_state, b_state;

  lsc_i2cm_arb #(.DEV_ADDR(7'h24), .INTERVAL(6'd30), .PRIO0(1'b1), .TMO_W(TMO_W)) u_dut_a (
    .clk(clk), .resetn(resetn), .bus(a_if), .dbg_state(a_state));
  lsc_i2cm_arb #(.DEV_ADDR(7'h24), .INTERVAL(6'd30), .PRIO0(1'b0), .TMO_W(TMO_W)) u_dut_b (
    .clk(clk), .resetn(resetn), .bus(b_if), .dbg_state(b_state));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got=%0h want=%0h at %0t", tag, got, want, $time);
    end
  endtask

  // scoreboard: {port, err, rdat} per ack and {rw, ofs, wdat} per run
  logic [9:0]  exp_q[$];
  logic [24:0] cmd_q[$];
  logic        b_exp_q[$];
  logic [7:0]  model_rdat = 8'h00;

  // engine model for instance A
  int         eng_lat = 3;
  bit         eng_hang = 1'b0;
  logic [7:0] eng_rd = 8'h00;
  bit         force_running = 1'b0;
  int         e_cnt = 0;
  bit         e_busy = 1'b0;
  bit         e_hang_l = 1'b0;
  logic       run_busy = 1'b0;

  initial begin
    a_if.m_running = 1'b0; a_if.m_done = 1'b0; a_if.m_rdat = 8'h00;
    forever begin
      @(posedge clk); #1;
      a_if.m_done = 1'b0;
      if (!resetn) begin
        e_busy = 1'b0;
      end else if (a_if.m_run) begin
        run_busy = a_if.m_running;
        e_busy = 1'b1; e_cnt = eng_lat; e_hang_l = eng_hang;
      end else if (e_busy) begin
        e_cnt--;
        if (e_cnt == 0) begin
          e_busy = 1'b0;
          if (!e_hang_l) begin a_if.m_done = 1'b1; a_if.m_rdat = eng_rd; end
        end
      end
      a_if.m_running = e_busy | force_running;
    end
  end

  // engine model for instance B: fixed two-cycle transfers
  int b_cnt = 0;
  initial begin
    b_if.m_running = 1'b0; b_if.m_done = 1'b0; b_if.m_rdat = 8'h3c;
    forever begin
      @(posedge clk); #1;
      b_if.m_done = 1'b0;
      if (b_if.m_run) b_cnt = 2;
      else if (b_cnt > 0) begin
        b_cnt--;
        if (b_cnt == 0) b_if.m_done = 1'b1;
      end
      b_if.m_running = (b_cnt > 0);
    end
  end

  // monitors
  int   cyc = 0, run_cyc = 0, done_cyc = 0, n_run = 0;
  logic prev_busy = 1'b0;
  logic [9:0]  ea;
  logic [24:0] ec;
  logic        eb;

  always @(negedge clk) begin
    cyc++;
    if (resetn) begin
      if (a_if.m_done) done_cyc = cyc;
      if (a_if.m_run) begin
        n_run++;
        run_cyc = cyc;
        check("run_after_grant", prev_busy, 1'b0);
        check("run_eng_idle", run_busy, 1'b0);
        ec = (cmd_q.size() > 0) ? cmd_q.pop_front() : 'x;
        check("cmd", {a_if.m_rw, a_if.m_ofs, a_if.m_wdat}, ec);
      end
      if (a_if.ack0 || a_if.ack1) begin
        ea = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        check("ack_port", {a_if.ack1, a_if.ack0}, ea[9] ? 2'b10 : 2'b01);
        check("ack_err", a_if.ack1 ? a_if.err1 : a_if.err0, ea[8]);
        check("ack_rdat", a_if.rdat, ea[7:0]);
        check("ack_lat", ea[8] ? (cyc - run_cyc) : (cyc - done_cyc), ea[8] ? TMO_LAT : 1);
      end
      if (b_if.ack0 || b_if.ack1) begin
        eb = (b_exp_q.size() > 0) ? b_exp_q.pop_front() : 1'bx;
        check("rr_port", {b_if.ack1, b_if.ack0}, eb ? 2'b10 : 2'b01);
      end
    end
    prev_busy = a_if.busy;
  end

  // driver tasks
  task automatic expect_txn(input int port, input bit rw, input logic [15:0] ofs,
                            input logic [7:0] wdat, input bit err, input logic [7:0] rd);
    cmd_q.push_back({rw, ofs, wdat});
    if (rw && !err) model_rdat = rd;
    exp_q.push_back({port[0], err, model_rdat});
  endtask

  task automatic drive(input int port, input bit rw, input logic [15:0] ofs, input logic [7:0] wdat);
    if (port == 0) begin a_if.rw0 = rw; a_if.ofs0 = ofs; a_if.wdat0 = wdat; a_if.req0 = 1'b1; end
    else           begin a_if.rw1 = rw; a_if.ofs1 = ofs; a_if.wdat1 = wdat; a_if.req1 = 1'b1; end
  endtask

  task automatic wait_ack(input int port);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = (port == 0) ? a_if.ack0 : a_if.ack1;
    end
    check("ack_seen", seen, 1'b1);
  endtask

  task automatic drop(input int port);
    @(posedge clk); #1;
    if (port == 0) a_if.req0 = 1'b0; else a_if.req1 = 1'b0;
  endtask

  task automatic txn(input int port, input bit rw, input logic [15:0] ofs,
                     input logic [7:0] wdat, input bit err, input logic [7:0] rd);
    eng_rd = rd;
    expect_txn(port, rw, ofs, wdat, err, rd);
    drive(port, rw, ofs, wdat);
    wait_ack(port);
    drop(port);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_ctl"}, {a_if.ack0, a_if.ack1, a_if.err0, a_if.err1, a_if.m_run, a_if.busy, a_state}, 8'h00);
    check({tag, "_dat"}, {a_if.rdat, a_if.m_rw, a_if.m_ofs}, 25'h0);
    check({tag, "_wdat"}, a_if.m_wdat, 8'h00);
  endtask

  initial begin
    #2000000;
    $display("FAIL sim_timeout at %0t", $time);
    $fatal(1);
  end

  initial begin
    bit         rw0, rw1, seen;
    logic [15:0] ofs0, ofs1;
    logic [7:0]  wd0, wd1;
    int          n0, nb, run_before;
    a_if.req0 = 0; a_if.req1 = 0; a_if.rw0 = 0; a_if.rw1 = 0;
    a_if.ofs0 = 0; a_if.ofs1 = 0; a_if.wdat0 = 0; a_if.wdat1 = 0;
    b_if.req0 = 0; b_if.req1 = 0; b_if.rw0 = 0; b_if.rw1 = 1;
    b_if.ofs0 = 16'h0010; b_if.ofs1 = 16'h0020; b_if.wdat0 = 8'h11; b_if.wdat1 = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outs("rst_in");
    #1 resetn = 1'b1;
    @(negedge clk);
    check_reset_outs("rst_out");
    check("m_dev", a_if.m_dev, 7'h24);
    check("m_intv", a_if.m_intv, 6'd30);
    @(posedge clk); #1;

    // single write, then a read whose data must persist after the ack
    txn(1, 1'b0, 16'h0202, 8'h55, 1'b0, 8'h00);
    txn(0, 1'b1, 16'h0000, 8'h00, 1'b0, 8'h01);
    repeat (3) @(negedge clk);
    check("rdat_held", a_if.rdat, 8'h01);
    @(posedge clk); #1;

    // strict priority under contention: four port-0 grants before port 1 gets one
    rw0 = 1'($urandom_range(0, 1)); ofs0 = 16'($urandom_range(0, 16'hffff)); wd0 = 8'($urandom_range(0, 255));
    rw1 = 1'($urandom_range(0, 1)); ofs1 = 16'($urandom_range(0, 16'hffff)); wd1 = 8'($urandom_range(0, 255));
    eng_rd = 8'($urandom_range(0, 255));
    for (int i = 0; i < 4; i++) expect_txn(0, rw0, ofs0, wd0, 1'b0, eng_rd);
    expect_txn(1, rw1, ofs1, wd1, 1'b0, eng_rd);
    drive(0, rw0, ofs0, wd0);
    drive(1, rw1, ofs1, wd1);
    n0 = 0;
    for (int i = 0; i < 400 && n0 < 4; i++) begin
      @(negedge clk);
      if (a_if.ack0) n0++;
    end
    check("prio_ack0_count", n0, 4);
    drop(0);
    wait_ack(1);
    drop(1);
    @(posedge clk); #1;

    // watchdog abort on a hung read; the engine stays busy past the abort,
    // so the following port-0 write must not be issued until it lets go
    eng_hang = 1'b1; eng_lat = 20;
    txn(1, 1'b1, 16'h1234, 8'h00, 1'b1, 8'h00);
    eng_hang = 1'b0; eng_lat = 3;
    txn(0, 1'b0, 16'h4321, 8'ha5, 1'b0, 8'h00);
    // completion on the last allowed S_WAIT cycle beats the watchdog
    eng_lat = 15;
    txn(1, 1'b1, 16'h00ff, 8'h00, 1'b0, 8'hc3);
    eng_lat = 3;
    @(posedge clk); #1;

    // engine busy in idle holds off the grant
    force_running = 1'b1;
    @(posedge clk); #1;
    run_before = n_run;
    eng_rd = 8'h00;
    expect_txn(1, 1'b0, 16'h0a0a, 8'h5a, 1'b0, 8'h00);
    drive(1, 1'b0, 16'h0a0a, 8'h5a);
    repeat (6) @(negedge clk);
    check("hold_busy", a_if.busy, 1'b0);
    check("hold_no_run", n_run, run_before);
    force_running = 1'b0;
    wait_ack(1);
    drop(1);
    @(posedge clk); #1;

    // reset in the middle of S_WAIT
    eng_lat = 10; eng_rd = 8'h77;
    cmd_q.push_back({1'b1, 16'h0abc, 8'h00});
    drive(0, 1'b1, 16'h0abc, 8'h00);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = a_if.m_run;
    end
    check("rst_run_seen", seen, 1'b1);
    repeat (3) @(negedge clk);
    check("rst_in_wait", a_state, 2'd2);
    @(posedge clk); #1;
    resetn = 1'b0;
    a_if.req0 = 1'b0;
    #1;
    check_reset_outs("rst_mid");
    exp_q.delete();
    cmd_q.delete();
    model_rdat = 8'h00;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    eng_lat = 3;
    @(posedge clk); #1;
    txn(1, 1'b1, 16'h0100, 8'h00, 1'b0, 8'h9e);

    // round-robin instance: both held, grants alternate 0,1,0,1
    b_exp_q.push_back(1'b0); b_exp_q.push_back(1'b1);
    b_exp_q.push_back(1'b0); b_exp_q.push_back(1'b1);
    b_if.req0 = 1'b1; b_if.req1 = 1'b1;
    nb = 0;
    for (int i = 0; i < 200 && nb < 4; i++) begin
      @(negedge clk);
      if (b_if.ack0 || b_if.ack1) nb++;
    end
    check("rr_ack_count", nb, 4);
    @(posedge clk); #1;
    b_if.req0 = 1'b0; b_if.req1 = 1'b0;

    repeat (8) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    check("cmd_q_drained", cmd_q.size(), 0);
    check("rr_q_drained", b_exp_q.size(), 0);
    check("idle_end", {a_if.busy, b_if.busy}, 2'b00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
